// File: rtl/reg_cmd_bridge.sv
// Register-command bridge: buffers processor write/read commands in a FIFO and
// issues them one at a time over a four-phase req/ack handshake with timeout.
module reg_cmd_bridge #(
    parameter int AW      = 6,
    parameter int DW      = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [AW-1:0]              p_address,
    input  logic [DW-1:0]              p_data,
    input  logic                       p_wr,
    input  logic                       p_rd,
    output logic                       p_full,
    output logic [$clog2(DEPTH):0]     q_level,
    output logic [DW-1:0]              p_data_back,
    output logic                       p_rd_valid,
    output logic                       p_err,
    input  logic                       p_err_clr,
    output logic                       m_req,
    output logic [AW-1:0]              m_addr,
    output logic [DW-1:0]              m_data,
    output logic                       m_wr,
    input  logic                       m_ack,
    input  logic [DW-1:0]              m_rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_e;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          wr;
    } cmd_t;

    cmd_t            mem_q [DEPTH];
    cmd_t            push_cmd;
    cmd_t            head_cmd;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW:0]     cnt_inc;
    logic            tmo;
    logic            m_req_q, m_req_d;
    logic [AW-1:0]   m_addr_q, m_addr_d;
    logic [DW-1:0]   m_data_q, m_data_d;
    logic            m_wr_q, m_wr_d;
    logic [DW-1:0]   data_back_q, data_back_d;
    logic            rd_valid_q, rd_valid_d;
    logic            err_q, err_d;
    logic            err_set;
    logic            full;
    logic            push;
    logic            pop;

    // Fullness is judged on the registered level, so a same-cycle pop never frees a slot early.
    assign full     = (level_q == LW'(DEPTH));
    assign push     = (p_wr | p_rd) & ~full;
    assign push_cmd = '{addr: p_address, data: p_data, wr: p_wr};
    assign head_cmd = mem_q[rd_ptr_q];

    // NOTE: command storage has no reset; the level counter alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_cmd;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    assign cnt_inc = {1'b0, cnt_q} + (CW + 1)'(1);
    assign tmo     = (TIMEOUT > 0) && (cnt_inc == (CW + 1)'(TIMEOUT));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        m_req_d     = m_req_q;
        m_addr_d    = m_addr_q;
        m_data_d    = m_data_q;
        m_wr_d      = m_wr_q;
        data_back_d = data_back_q;
        rd_valid_d  = 1'b0;
        err_set     = 1'b0;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if ((level_q != '0) && !m_ack) begin
                    pop      = 1'b1;
                    m_req_d  = 1'b1;
                    m_addr_d = head_cmd.addr;
                    m_data_d = head_cmd.data;
                    m_wr_d   = head_cmd.wr;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (m_ack) begin
                    m_req_d = 1'b0;
                    if (!m_wr_q) begin
                        data_back_d = m_rdata;
                        rd_valid_d  = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = RELEASE;
                end else if (tmo) begin
                    m_req_d = 1'b0;
                    err_set = 1'b1;
                    cnt_d   = '0;
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_inc[CW-1:0];
                end
            end
            RELEASE: begin
                if (!m_ack) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (tmo) begin
                    err_set = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc[CW-1:0];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A timeout in the same cycle as a clear must still leave the flag set.
        err_d = err_set ? 1'b1 : (p_err_clr ? 1'b0 : err_q);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cnt_q       <= '0;
            m_req_q     <= 1'b0;
            m_addr_q    <= '0;
            m_data_q    <= '0;
            m_wr_q      <= 1'b0;
            data_back_q <= '0;
            rd_valid_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            m_req_q     <= m_req_d;
            m_addr_q    <= m_addr_d;
            m_data_q    <= m_data_d;
            m_wr_q      <= m_wr_d;
            data_back_q <= data_back_d;
            rd_valid_q  <= rd_valid_d;
            err_q       <= err_d;
        end
    end

    assign p_full      = full;
    assign q_level     = level_q;
    assign p_data_back = data_back_q;
    assign p_rd_valid  = rd_valid_q;
    assign p_err       = err_q;
    assign m_req       = m_req_q;
    assign m_addr      = m_addr_q;
    assign m_data      = m_data_q;
    assign m_wr        = m_wr_q;

endmodule

// File: tb/tb_reg_cmd_bridge.sv
// Directed bench for reg_cmd_bridge: reset, write, read, full/ordering,
// handshake timeouts and reset during a transaction.
module tb_reg_cmd_bridge;

    localparam int AW      = 6;
    localparam int DW      = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic                    clk;
    logic                    rst_n;
    logic [AW-1:0]           p_address;
    logic [DW-1:0]           p_data;
    logic                    p_wr;
    logic                    p_rd;
    logic                    p_full;
    logic [$clog2(DEPTH):0]  q_level;
    logic [DW-1:0]           p_data_back;
    logic                    p_rd_valid;
    logic                    p_err;
    logic                    p_err_clr;
    logic                    m_req;
    logic [AW-1:0]           m_addr;
    logic [DW-1:0]           m_data;
    logic                    m_wr;
    logic                    m_ack;
    logic [DW-1:0]           m_rdata;

    int checks   = 0;
    int failures = 0;

    reg_cmd_bridge #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .p_address(p_address), .p_data(p_data), .p_wr(p_wr), .p_rd(p_rd),
        .p_full(p_full), .q_level(q_level),
        .p_data_back(p_data_back), .p_rd_valid(p_rd_valid),
        .p_err(p_err), .p_err_clr(p_err_clr),
        .m_req(m_req), .m_addr(m_addr), .m_data(m_data), .m_wr(m_wr),
        .m_ack(m_ack), .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic wr, input logic rd);
        p_address = a;
        p_data    = d;
        p_wr      = wr;
        p_rd      = rd;
        tick();
        p_wr = 1'b0;
        p_rd = 1'b0;
    endtask

    task automatic wait_req(input int max_cycles, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n <= max_cycles) begin
            if (m_req) begin
                ok = 1'b1;
                break;
            end
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        logic [63:0] outs;
        rst_n = 1'b1;
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        outs = 64'({m_req, m_wr, p_rd_valid, p_err, p_full, q_level, m_addr, m_data, p_data_back});
        checks++;
        if (outs !== 64'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", outs);
        end
        tick();
        #3;
        rst_n = 1'b1;
        tick();
        checks++;
        if (q_level !== '0 || p_full !== 1'b0) begin
            failures++;
            $display("FAIL reset_release q_level=%0d p_full=%0b want 0/0", q_level, p_full);
        end
    endtask

    task automatic test_write();
        bit quiet;
        push_cmd(6'h2A, 16'hBEEF, 1'b1, 1'b0);
        checks++;
        if (q_level !== 3'd1) begin
            failures++;
            $display("FAIL write_enqueue q_level=%0d want 1", q_level);
        end
        tick();
        checks++;
        if (m_req !== 1'b1 || m_addr !== 6'h2A || m_data !== 16'hBEEF || m_wr !== 1'b1 || q_level !== 3'd0) begin
            failures++;
            $display("FAIL write_issue req=%0b addr=%h data=%h wr=%0b lvl=%0d want 1/2a/beef/1/0",
                     m_req, m_addr, m_data, m_wr, q_level);
        end
        tick();
        checks++;
        if (m_req !== 1'b1) begin
            failures++;
            $display("FAIL write_hold_req m_req=%0b want 1", m_req);
        end
        m_ack = 1'b1;
        tick();
        checks++;
        if (m_req !== 1'b0 || p_rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL write_ack m_req=%0b p_rd_valid=%0b want 0/0", m_req, p_rd_valid);
        end
        m_ack = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (m_req !== 1'b0 || p_rd_valid !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1 || m_addr !== 6'h2A || m_data !== 16'hBEEF) begin
            failures++;
            $display("FAIL write_single_handshake quiet=%0b addr=%h data=%h want 1/2a/beef", quiet, m_addr, m_data);
        end
    endtask

    task automatic test_read();
        push_cmd(6'h05, 16'h0000, 1'b0, 1'b1);
        tick();
        checks++;
        if (m_req !== 1'b1 || m_wr !== 1'b0 || m_addr !== 6'h05) begin
            failures++;
            $display("FAIL read_issue req=%0b wr=%0b addr=%h want 1/0/05", m_req, m_wr, m_addr);
        end
        m_ack   = 1'b1;
        m_rdata = 16'h1234;
        tick();
        checks++;
        if (m_req !== 1'b0 || p_rd_valid !== 1'b1 || p_data_back !== 16'h1234) begin
            failures++;
            $display("FAIL read_data req=%0b valid=%0b data=%h want 0/1/1234", m_req, p_rd_valid, p_data_back);
        end
        m_ack   = 1'b0;
        m_rdata = 16'h0000;
        tick();
        checks++;
        if (p_rd_valid !== 1'b0 || p_data_back !== 16'h1234) begin
            failures++;
            $display("FAIL read_pulse valid=%0b data=%h want 0/1234", p_rd_valid, p_data_back);
        end
    endtask

    task automatic test_both();
        push_cmd(6'h11, 16'h5A5A, 1'b1, 1'b1);
        tick();
        checks++;
        if (m_req !== 1'b1 || m_wr !== 1'b1 || m_data !== 16'h5A5A) begin
            failures++;
            $display("FAIL both_issue req=%0b wr=%0b data=%h want 1/1/5a5a", m_req, m_wr, m_data);
        end
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        tick();
        tick();
        checks++;
        if (m_req !== 1'b0 || q_level !== 3'd0 || p_rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL both_read_dropped req=%0b lvl=%0d valid=%0b want 0/0/0", m_req, q_level, p_rd_valid);
        end
    endtask

    task automatic test_full();
        bit ok;
        for (int i = 1; i <= 6; i++) begin
            push_cmd(6'(i), 16'(i), 1'b1, 1'b0);
        end
        checks++;
        if (q_level !== 3'd4 || p_full !== 1'b1 || m_req !== 1'b1 || m_data !== 16'd1) begin
            failures++;
            $display("FAIL full_state lvl=%0d full=%0b req=%0b data=%0d want 4/1/1/1", q_level, p_full, m_req, m_data);
        end
        for (int i = 1; i <= 5; i++) begin
            wait_req(8, ok);
            checks++;
            if (!ok || m_data !== 16'(i)) begin
                failures++;
                $display("FAIL full_order idx=%0d got_req=%0b got_data=%0d want data=%0d", i, ok, m_data, i);
            end
            m_ack = 1'b1;
            tick();
            m_ack = 1'b0;
            tick();
        end
        tick();
        tick();
        tick();
        checks++;
        if (m_req !== 1'b0 || q_level !== 3'd0 || p_full !== 1'b0) begin
            failures++;
            $display("FAIL full_drain req=%0b lvl=%0d full=%0b want 0/0/0", m_req, q_level, p_full);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        push_cmd(6'h30, 16'hA1A1, 1'b1, 1'b0);
        push_cmd(6'h31, 16'hB2B2, 1'b1, 1'b0);
        checks++;
        if (m_req !== 1'b1 || m_data !== 16'hA1A1) begin
            failures++;
            $display("FAIL tmo_issue req=%0b data=%h want 1/a1a1", m_req, m_data);
        end
        n = 0;
        while (m_req && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n !== TIMEOUT || p_err !== 1'b1) begin
            failures++;
            $display("FAIL tmo_req_cycles cycles=%0d err=%0b want %0d/1", n, p_err, TIMEOUT);
        end
        wait_req(4, ok);
        checks++;
        if (!ok || m_data !== 16'hB2B2) begin
            failures++;
            $display("FAIL tmo_next_issue got_req=%0b data=%h want 1/b2b2", ok, m_data);
        end
        p_err_clr = 1'b1;
        tick();
        p_err_clr = 1'b0;
        checks++;
        if (p_err !== 1'b0) begin
            failures++;
            $display("FAIL tmo_err_clr err=%0b want 0", p_err);
        end
        // Ack is held high so the release phase itself times out.
        m_ack = 1'b1;
        tick();
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        checks++;
        if (p_err !== 1'b0 || m_req !== 1'b0) begin
            failures++;
            $display("FAIL tmo_release_early err=%0b req=%0b want 0/0", p_err, m_req);
        end
        tick();
        checks++;
        if (p_err !== 1'b1) begin
            failures++;
            $display("FAIL tmo_release err=%0b want 1", p_err);
        end
        m_ack = 1'b0;
        tick();
        p_err_clr = 1'b1;
        tick();
        p_err_clr = 1'b0;
        push_cmd(6'h32, 16'h0000, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        checks++;
        if (m_req !== 1'b1 || p_err !== 1'b0) begin
            failures++;
            $display("FAIL tmo_read_pending req=%0b err=%0b want 1/0", m_req, p_err);
        end
        p_err_clr = 1'b1;
        tick();
        p_err_clr = 1'b0;
        checks++;
        if (p_err !== 1'b1 || m_req !== 1'b0 || p_rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL tmo_set_wins err=%0b req=%0b valid=%0b want 1/0/0", p_err, m_req, p_rd_valid);
        end
        tick();
        checks++;
        if (p_err !== 1'b1 || p_rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL tmo_sticky err=%0b valid=%0b want 1/0", p_err, p_rd_valid);
        end
    endtask

    task automatic test_reset_mid();
        bit quiet;
        for (int i = 0; i < 4; i++) begin
            push_cmd(6'(8'h10 + i), 16'(16'h100 + i), 1'b1, 1'b0);
        end
        checks++;
        if (m_req !== 1'b1 || q_level !== 3'd3) begin
            failures++;
            $display("FAIL rstmid_setup req=%0b lvl=%0d want 1/3", m_req, q_level);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_req !== 1'b0 || q_level !== 3'd0 || p_err !== 1'b0 || m_data !== 16'd0) begin
            failures++;
            $display("FAIL rstmid_async req=%0b lvl=%0d err=%0b data=%h want 0/0/0/0", m_req, q_level, p_err, m_data);
        end
        tick();
        #3;
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (m_req !== 1'b0 || q_level !== 3'd0) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_no_stale req=%0b lvl=%0d want 0/0 throughout", m_req, q_level);
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        p_address = '0;
        p_data    = '0;
        p_wr      = 1'b0;
        p_rd      = 1'b0;
        p_err_clr = 1'b0;
        m_ack     = 1'b0;
        m_rdata   = '0;
        test_reset();
        test_write();
        test_read();
        test_both();
        test_full();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
